streaming_tagged_count_collector: RTL and testbench
===================================================

Name: streaming_tagged_count_collector

Overview:
In-order streaming front/back end for a bank of out-of-order connected-count compute lanes; successor to the fixed-rotation 512-slot collector.
- Tags each accepted graph with a ring slot and dispatches it round-robin to one of NUM_LANES lanes.
- Gathers out-of-order results through a per-slot scoreboard and retires them strictly in input order with valid/ready backpressure.
- Adds skip entries, an almost-full threshold, tag-error detection and a head-of-line watchdog.

Parameters:
NUM_LANES, 2, number of compute lanes
GRAPH_WIDTH, 128, graph payload width
COUNT_WIDTH, 6, result count width
EXTRA_DATA_WIDTH, 1, sideband carried input->output untouched
ADDR_WIDTH, 5, log2 of ring depth; DEPTH = 2^ADDR_WIDTH
ALMOST_FULL_MARGIN, 4, almost_full asserts when occupancy >= DEPTH-ALMOST_FULL_MARGIN
TIMEOUT_CYCLES, 4096, head watchdog limit; 0 disables

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  input entry offered
in_ready  out  1  entry accepted when in_valid&&in_ready
in_skip  in  1  entry consumes a slot, not dispatched, result count 0
in_graph  in  GRAPH_WIDTH  graph payload
in_extra  in  EXTRA_DATA_WIDTH  sideband
almost_full  out  1  occupancy threshold flag
occupancy  out  ADDR_WIDTH+1  allocated slots, 0..DEPTH
lane_ready  in  NUM_LANES  lane i can take a job next cycle
lane_valid  out  NUM_LANES  one-hot dispatch pulse
lane_graph  out  GRAPH_WIDTH  shared dispatch payload
lane_tag  out  ADDR_WIDTH  slot tag of dispatched job
lane_done  in  NUM_LANES  lane i result valid (1-cycle pulse)
lane_count  in  NUM_LANES*COUNT_WIDTH  lane i count, slice i
lane_tag_out  in  NUM_LANES*ADDR_WIDTH  lane i returned tag, slice i
out_valid  out  1  in-order result available
out_ready  in  1  consumer accepts
out_count  out  COUNT_WIDTH  result count
out_extra  out  EXTRA_DATA_WIDTH  sideband of that entry
out_skipped  out  1  entry was a skip
err_tag  out  1  sticky: bad returned tag
err_timeout  out  1  sticky: head watchdog expired

Behaviour:
- Reset: head=tail=0, occupancy=0, busy[]=done[]=0, rr pointer=0, lane_valid=0, lane_graph/lane_tag=0, out_valid=0, out_count/out_extra/out_skipped=0, err_tag=err_timeout=0, watchdog=0. Reset mid-operation discards every in-flight entry. Lanes are reset alongside this block. A lane_done arriving after reset for a now non-busy slot sets err_tag.
- Acceptance: in_ready = (occupancy != DEPTH) && |lane_ready. It is independent of in_skip and in_valid, and a same-cycle pop does not free space for acceptance.
- On accept at cycle t: slot=tail; store extra and skip bit; busy[tail]=1; tail++ (mod DEPTH).
  - Non-skip: grant = first lane with lane_ready set, searching from the rr pointer upward with wrap. The rr pointer moves to grant+1. lane_valid[grant]=1, lane_graph and lane_tag are registered and valid in cycle t+1 for exactly one cycle.
  - Skip: no dispatch, the rr pointer is unchanged, done[slot]=1 with count 0 at the end of cycle t.
- Result capture: for each lane i with lane_done[i] and slot s=tag_i, if busy[s]&&!done[s], write count[s] and set done[s]. All lanes are written in parallel; storage is flop-based.
  - Tag not busy or already done: write ignored, err_tag=1.
  - Two lanes return the same tag in one cycle: the lowest index lane wins and err_tag=1.
- Retire: the output stage loads when (!out_valid||out_ready) && occupancy!=0 && done[head]. The load clears busy/done[head], increments head and sets out_valid next cycle. Otherwise out_valid drops after a handshake with nothing loadable.
- Latency: lane_done at cycle t for the head slot gives out_valid at t+2. A skip accepted at t into an empty ring gives out_valid at t+2. With out_ready held high, throughput is 1 result/cycle.
- Occupancy arithmetic: +1 on accept, -1 on retire-load, unchanged when both happen. It never exceeds DEPTH, and tail wraps modulo DEPTH.
- almost_full is combinational from occupancy. With ALMOST_FULL_MARGIN >= DEPTH it is constantly 1.
- Watchdog counter:
  - Increments each cycle occupancy!=0 && !done[head].
  - Clears on retire or when occupancy==0.
  - Reaching TIMEOUT_CYCLES sets err_timeout and saturates; this flag does not block flow.
- Output fields hold stable while out_valid && !out_ready.

Test Plan:
- DEPTH=4, NUM_LANES=2, all lane_ready=1: send 3 graphs -> lane_valid 01,10,01 with tags 0,1,2. Return tags in order 2,0,1 -> outputs in order tag0,tag1,tag2; first out_valid 2 cycles after tag 0 done.
- Fill 4 entries with no lane_done -> in_ready=0, occupancy=4, almost_full=1 (margin 1). One retire-load -> in_ready=1 the following cycle.
- Skip entry between two real entries: the skip emits out_count=0, out_skipped=1 in its order slot, and the rr pointer is not advanced.
- lane_done with tag 3 when slot 3 is not busy -> err_tag=1, occupancy unchanged, no output. Lanes 0 and 1 both returning tag 0 -> lane 0 count kept, err_tag=1.
- Backpressure: out_ready=0 for 10 cycles with 2 done entries -> out_valid held, fields stable. Then out_ready=1 -> 2 results on consecutive cycles.
- TIMEOUT_CYCLES=16, head never completes -> err_timeout=1 after 16 cycles. Assert rst mid-stream -> all outputs return to reset values.

Source files
------------

// File: rtl/streaming_tagged_count_collector.sv
// In-order collector for a bank of out-of-order count lanes: tags each accepted graph
// with a ring slot, dispatches round-robin, and retires results in acceptance order.

module streaming_tagged_count_collector_lane #(
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 32
) (
  input  logic                  done_i,
  input  logic [ADDR_WIDTH-1:0] tag_i,
  input  logic [DEPTH-1:0]      busy_i,
  input  logic [DEPTH-1:0]      slot_done_i,
  output logic                  hit_o,
  output logic                  bad_o
);
  assign hit_o = done_i && busy_i[tag_i] && !slot_done_i[tag_i];
  assign bad_o = done_i && !hit_o;
endmodule

module streaming_tagged_count_collector #(
  parameter int NUM_LANES          = 2,
  parameter int GRAPH_WIDTH        = 128,
  parameter int COUNT_WIDTH        = 6,
  parameter int EXTRA_DATA_WIDTH   = 1,
  parameter int ADDR_WIDTH         = 5,
  parameter int ALMOST_FULL_MARGIN = 4,
  parameter int TIMEOUT_CYCLES     = 4096
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              in_skip,
  input  logic [GRAPH_WIDTH-1:0]            in_graph,
  input  logic [EXTRA_DATA_WIDTH-1:0]       in_extra,
  output logic                              almost_full,
  output logic [ADDR_WIDTH:0]               occupancy,
  input  logic [NUM_LANES-1:0]              lane_ready,
  output logic [NUM_LANES-1:0]              lane_valid,
  output logic [GRAPH_WIDTH-1:0]            lane_graph,
  output logic [ADDR_WIDTH-1:0]             lane_tag,
  input  logic [NUM_LANES-1:0]              lane_done,
  input  logic [NUM_LANES*COUNT_WIDTH-1:0]  lane_count,
  input  logic [NUM_LANES*ADDR_WIDTH-1:0]   lane_tag_out,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [COUNT_WIDTH-1:0]            out_count,
  output logic [EXTRA_DATA_WIDTH-1:0]       out_extra,
  output logic                              out_skipped,
  output logic                              err_tag,
  output logic                              err_timeout
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int LW    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int WD_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);
  localparam int AF_TH = DEPTH - ALMOST_FULL_MARGIN;
  // A non-positive threshold makes the compare trivially true: almost_full stays high.
  localparam logic [ADDR_WIDTH:0] AF_TH_V = (AF_TH <= 0) ? '0 : (ADDR_WIDTH+1)'(AF_TH);
  localparam logic [ADDR_WIDTH:0] FULL    = (ADDR_WIDTH+1)'(DEPTH);

  typedef struct packed {
    logic [COUNT_WIDTH-1:0]      count;
    logic [EXTRA_DATA_WIDTH-1:0] extra;
    logic                        skip;
  } slot_t;

  slot_t                          slot_q [DEPTH];
  logic [DEPTH-1:0]               busy_q, done_q;
  logic [ADDR_WIDTH-1:0]          head_q, tail_q;
  logic [ADDR_WIDTH:0]            occ_q;
  logic [LW-1:0]                  rr_q;
  logic [NUM_LANES-1:0]           lane_valid_q;
  logic [GRAPH_WIDTH-1:0]         lane_graph_q;
  logic [ADDR_WIDTH-1:0]          lane_tag_q;
  logic                           out_valid_q, out_skipped_q;
  logic [COUNT_WIDTH-1:0]         out_count_q;
  logic [EXTRA_DATA_WIDTH-1:0]    out_extra_q;
  logic                           err_tag_q, err_timeout_q;
  logic [WD_W-1:0]                wd_q, wd_d;

  logic [NUM_LANES-1:0][ADDR_WIDTH-1:0]  ltag;
  logic [NUM_LANES-1:0][COUNT_WIDTH-1:0] lcnt;
  logic [NUM_LANES-1:0]                  hit, bad, cap_we;
  logic                                  dup_err;
  logic [LW-1:0]                         grant, rr_next;
  logic                                  found;
  int                                    idx;
  logic                                  accept, load;

  assign ltag = lane_tag_out;
  assign lcnt = lane_count;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    streaming_tagged_count_collector_lane #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
    ) u_lane (
      .done_i      (lane_done[i]),
      .tag_i       (ltag[i]),
      .busy_i      (busy_q),
      .slot_done_i (done_q),
      .hit_o       (hit[i]),
      .bad_o       (bad[i])
    );
  end

  // Lowest lane index wins when several lanes return the same tag in one cycle.
  always_comb begin
    cap_we  = '0;
    dup_err = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (hit[i]) begin
        cap_we[i] = 1'b1;
        for (int j = 0; j < i; j++)
          if (lane_done[j] && ltag[j] == ltag[i]) cap_we[i] = 1'b0;
        if (!cap_we[i]) dup_err = 1'b1;
      end
    end
  end

  always_comb begin
    grant = rr_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_LANES; k++) begin
      idx = (int'(rr_q) + k) % NUM_LANES;
      if (!found && lane_ready[idx[LW-1:0]]) begin
        grant = idx[LW-1:0];
        found = 1'b1;
      end
    end
  end

  assign rr_next = (int'(grant) == NUM_LANES - 1) ? '0 : grant + 1'b1;

  assign in_ready = (occ_q != FULL) && (|lane_ready);
  assign accept   = in_valid && in_ready;
  assign load     = (!out_valid_q || out_ready) && (occ_q != '0) && done_q[head_q];

  always_comb begin
    wd_d = wd_q;
    if (load || occ_q == '0)                 wd_d = '0;
    else if (!done_q[head_q] && wd_q != WD_MAX) wd_d = wd_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < DEPTH; s++) slot_q[s] <= '0;
      busy_q        <= '0;
      done_q        <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      occ_q         <= '0;
      rr_q          <= '0;
      lane_valid_q  <= '0;
      lane_graph_q  <= '0;
      lane_tag_q    <= '0;
      out_valid_q   <= 1'b0;
      out_count_q   <= '0;
      out_extra_q   <= '0;
      out_skipped_q <= 1'b0;
      err_tag_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      wd_q          <= '0;
    end else begin
      lane_valid_q <= '0;
      if (accept) begin
        slot_q[tail_q] <= '{count: '0, extra: in_extra, skip: in_skip};
        busy_q[tail_q] <= 1'b1;
        done_q[tail_q] <= in_skip;
        tail_q         <= tail_q + 1'b1;
        if (!in_skip) begin
          lane_valid_q[grant] <= 1'b1;
          lane_graph_q        <= in_graph;
          lane_tag_q          <= tail_q;
          rr_q                <= rr_next;
        end
      end

      for (int i = 0; i < NUM_LANES; i++) begin
        if (cap_we[i]) begin
          slot_q[ltag[i]].count <= lcnt[i];
          done_q[ltag[i]]       <= 1'b1;
        end
      end

      if (load) begin
        busy_q[head_q] <= 1'b0;
        done_q[head_q] <= 1'b0;
        head_q         <= head_q + 1'b1;
        out_valid_q    <= 1'b1;
        out_count_q    <= slot_q[head_q].count;
        out_extra_q    <= slot_q[head_q].extra;
        out_skipped_q  <= slot_q[head_q].skip;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      case ({accept, load})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase

      err_tag_q     <= err_tag_q | (|bad) | dup_err;
      wd_q          <= wd_d;
      err_timeout_q <= err_timeout_q | ((TIMEOUT_CYCLES > 0) && (wd_d == WD_MAX));
    end
  end

  assign almost_full = (occ_q >= AF_TH_V);
  assign occupancy   = occ_q;
  assign lane_valid  = lane_valid_q;
  assign lane_graph  = lane_graph_q;
  assign lane_tag    = lane_tag_q;
  assign out_valid   = out_valid_q;
  assign out_count   = out_count_q;
  assign out_extra   = out_extra_q;
  assign out_skipped = out_skipped_q;
  assign err_tag     = err_tag_q;
  assign err_timeout = err_timeout_q;
endmodule

// File: tb/tb_streaming_tagged_count_collector.sv
// Directed bench for streaming_tagged_count_collector: 4-slot ring, two lanes, scoreboarded outputs.

module tb_streaming_tagged_count_collector;
  localparam int NL = 2, GW = 16, CW = 6, XW = 1, AW = 2, DEPTH = 4;

  logic              clk = 1'b0, rst = 1'b1;
  logic              in_valid, in_ready, in_skip, almost_full;
  logic [GW-1:0]     in_graph, lane_graph;
  logic [XW-1:0]     in_extra, out_extra;
  logic [AW:0]       occupancy;
  logic [NL-1:0]     lane_ready, lane_valid, lane_done;
  logic [AW-1:0]     lane_tag;
  logic [NL*CW-1:0]  lane_count;
  logic [NL*AW-1:0]  lane_tag_out;
  logic              out_valid, out_ready, out_skipped, err_tag, err_timeout;
  logic [CW-1:0]     out_count;

  streaming_tagged_count_collector #(
    .NUM_LANES(NL), .GRAPH_WIDTH(GW), .COUNT_WIDTH(CW), .EXTRA_DATA_WIDTH(XW),
    .ADDR_WIDTH(AW), .ALMOST_FULL_MARGIN(1), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_skip(in_skip),
    .in_graph(in_graph), .in_extra(in_extra), .almost_full(almost_full),
    .occupancy(occupancy), .lane_ready(lane_ready), .lane_valid(lane_valid),
    .lane_graph(lane_graph), .lane_tag(lane_tag), .lane_done(lane_done),
    .lane_count(lane_count), .lane_tag_out(lane_tag_out), .out_valid(out_valid),
    .out_ready(out_ready), .out_count(out_count), .out_extra(out_extra),
    .out_skipped(out_skipped), .err_tag(err_tag), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] count;
    logic [XW-1:0] extra;
    logic          skip;
  } exp_t;

  exp_t          sb[$];
  logic [GW-1:0] graph_by_tag [DEPTH];
  logic [AW-1:0] tb_tail;
  int            vectors = 0, miscompares = 0;

  function automatic logic [CW-1:0] cnt_of(input logic [GW-1:0] g);
    return g[CW-1:0] ^ g[GW-1 -: CW];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Samples the output handshake mid-cycle, then advances to just after the next edge.
  task automatic nxt();
    exp_t e;
    @(negedge clk);
    if (!rst && out_valid && out_ready) begin
      chk("out_expected", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("out_fields", 64'({out_count, out_extra, out_skipped}), 64'(e));
      end
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    lane_done = '0;
  endtask

  task automatic send(input logic [GW-1:0] g, input logic [XW-1:0] x, input logic s);
    exp_t e;
    in_valid = 1'b1; in_graph = g; in_extra = x; in_skip = s;
    #1 chk("in_ready_on_send", 64'(in_ready), 64'd1);
    e.count = s ? '0 : cnt_of(g);
    e.extra = x;
    e.skip  = s;
    sb.push_back(e);
    graph_by_tag[tb_tail] = g;
    tb_tail++;
  endtask

  task automatic ret(input int ln, input logic [AW-1:0] tag, input logic [CW-1:0] c);
    lane_done[ln]              = 1'b1;
    lane_tag_out[ln*AW +: AW]  = tag;
    lane_count[ln*CW +: CW]    = c;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    nxt(); nxt();
    rst = 1'b0;
    sb.delete();
    tb_tail = '0;
  endtask

  task automatic drain(input int n, input string tag);
    for (int k = 0; k < n; k++) nxt();
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    in_valid = 0; in_skip = 0; in_graph = '0; in_extra = '0;
    lane_ready = '1; lane_done = '0; lane_count = '0; lane_tag_out = '0;
    out_ready = 1'b1; tb_tail = '0;

    // Reset values
    do_reset();
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_almost_full", 64'(almost_full), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_lane_valid", 64'(lane_valid), 64'd0);
    chk("rst_lane_tag", 64'(lane_tag), 64'd0);
    chk("rst_lane_graph", 64'(lane_graph), 64'd0);
    chk("rst_out_count", 64'(out_count), 64'd0);
    chk("rst_err_tag", 64'(err_tag), 64'd0);
    chk("rst_err_timeout", 64'(err_timeout), 64'd0);

    // Round-robin dispatch and out-of-order return
    send(16'hA1C3, 1'b1, 1'b0); nxt();
    chk("t1_lv0", 64'(lane_valid), 64'b01); chk("t1_tag0", 64'(lane_tag), 64'd0);
    chk("t1_graph0", 64'(lane_graph), 64'hA1C3);
    send(16'h5B27, 1'b0, 1'b0); nxt();
    chk("t1_lv1", 64'(lane_valid), 64'b10); chk("t1_tag1", 64'(lane_tag), 64'd1);
    send(16'h3E90, 1'b1, 1'b0); nxt();
    chk("t1_lv2", 64'(lane_valid), 64'b01); chk("t1_tag2", 64'(lane_tag), 64'd2);
    nxt();
    chk("t1_lv_idle", 64'(lane_valid), 64'd0);
    ret(0, 2'd2, cnt_of(graph_by_tag[2])); nxt();
    ret(0, 2'd0, cnt_of(graph_by_tag[0])); nxt();
    ret(1, 2'd1, cnt_of(graph_by_tag[1]));
    chk("t1_ov_lat1", 64'(out_valid), 64'd0);
    nxt();
    chk("t1_ov_lat2", 64'(out_valid), 64'd1);
    chk("t1_first_count", 64'(out_count), 64'(cnt_of(16'hA1C3)));
    drain(4, "t1_drained");

    // Fill to full, then one retire frees space a cycle later
    do_reset();
    send(16'h0101, 1'b0, 1'b0); nxt();
    send(16'h0202, 1'b1, 1'b0); nxt();
    chk("t2_af_occ2", 64'(almost_full), 64'd0);
    send(16'h0303, 1'b0, 1'b0); nxt();
    chk("t2_af_occ3", 64'(almost_full), 64'd1);
    send(16'h0404, 1'b1, 1'b0); nxt();
    chk("t2_occ_full", 64'(occupancy), 64'd4);
    chk("t2_in_ready_full", 64'(in_ready), 64'd0);
    chk("t2_af_full", 64'(almost_full), 64'd1);
    ret(0, 2'd0, cnt_of(graph_by_tag[0])); nxt();
    chk("t2_in_ready_pop_cycle", 64'(in_ready), 64'd0);
    nxt();
    chk("t2_in_ready_after", 64'(in_ready), 64'd1);
    chk("t2_occ_after", 64'(occupancy), 64'd3);
    ret(1, 2'd1, cnt_of(graph_by_tag[1])); nxt();
    ret(0, 2'd2, cnt_of(graph_by_tag[2])); nxt();
    ret(1, 2'd3, cnt_of(graph_by_tag[3]));
    drain(4, "t2_drained");
    chk("t2_occ_empty", 64'(occupancy), 64'd0);

    // Skip between real entries keeps the rr pointer; skip into empty ring
    do_reset();
    send(16'h7711, 1'b1, 1'b0); nxt();
    chk("t3_lv_a", 64'(lane_valid), 64'b01);
    send(16'hFFFF, 1'b0, 1'b1); nxt();
    chk("t3_lv_skip", 64'(lane_valid), 64'd0);
    send(16'h2468, 1'b1, 1'b0); nxt();
    chk("t3_lv_b", 64'(lane_valid), 64'b10);
    chk("t3_tag_b", 64'(lane_tag), 64'd2);
    ret(1, 2'd2, cnt_of(graph_by_tag[2])); nxt();
    ret(0, 2'd0, cnt_of(graph_by_tag[0]));
    drain(5, "t3_drained");
    chk("t3_occ_empty", 64'(occupancy), 64'd0);
    send(16'h0000, 1'b1, 1'b1); nxt();
    chk("t3_skip_lat1", 64'(out_valid), 64'd0);
    nxt();
    chk("t3_skip_lat2", 64'(out_valid), 64'd1);
    chk("t3_skip_flag", 64'(out_skipped), 64'd1);
    chk("t3_skip_count", 64'(out_count), 64'd0);
    drain(2, "t3_skip_drained");

    // Bad tag and duplicate tag
    do_reset();
    ret(0, 2'd3, 6'h2A); nxt();
    chk("t4_err_tag_bad", 64'(err_tag), 64'd1);
    chk("t4_occ_bad", 64'(occupancy), 64'd0);
    chk("t4_ov_bad", 64'(out_valid), 64'd0);
    do_reset();
    send(16'h9C4E, 1'b0, 1'b0); nxt(); nxt();
    chk("t4_err_tag_clean", 64'(err_tag), 64'd0);
    ret(0, 2'd0, cnt_of(graph_by_tag[0]));
    ret(1, 2'd0, cnt_of(graph_by_tag[0]) ^ 6'h3F);
    nxt();
    chk("t4_err_tag_dup", 64'(err_tag), 64'd1);
    drain(3, "t4_drained");

    // Backpressure with two completed entries returned in the same cycle
    do_reset();
    out_ready = 1'b0;
    send(16'h1234, 1'b1, 1'b0); nxt();
    send(16'h0F0F, 1'b0, 1'b0); nxt();
    ret(0, 2'd0, cnt_of(graph_by_tag[0]));
    ret(1, 2'd1, cnt_of(graph_by_tag[1]));
    nxt(); nxt();
    for (int k = 0; k < 10; k++) begin
      chk("t5_hold_valid", 64'(out_valid), 64'd1);
      chk("t5_hold_count", 64'(out_count), 64'(cnt_of(16'h1234)));
      chk("t5_hold_extra", 64'(out_extra), 64'd1);
      nxt();
    end
    out_ready = 1'b1;
    #1 chk("t5_rel_v0", 64'(out_valid), 64'd1);
    nxt();
    chk("t5_rel_v1", 64'(out_valid), 64'd1);
    chk("t5_rel_c1", 64'(out_count), 64'(cnt_of(16'h0F0F)));
    nxt();
    chk("t5_rel_idle", 64'(out_valid), 64'd0);
    chk("t5_drained", 64'(sb.size()), 64'd0);

    // Watchdog on a head that never completes, then reset mid-stream
    do_reset();
    send(16'h4242, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) nxt();
    chk("t6_timeout_early", 64'(err_timeout), 64'd0);
    for (int k = 0; k < 10; k++) nxt();
    chk("t6_timeout_set", 64'(err_timeout), 64'd1);
    chk("t6_in_ready", 64'(in_ready), 64'd1);
    chk("t6_occ", 64'(occupancy), 64'd1);
    rst = 1'b1;
    nxt();
    chk("t6_rst_occ", 64'(occupancy), 64'd0);
    chk("t6_rst_err_timeout", 64'(err_timeout), 64'd0);
    chk("t6_rst_out_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_lane_graph", 64'(lane_graph), 64'd0);
    chk("t6_rst_lane_tag", 64'(lane_tag), 64'd0);
    chk("t6_rst_lane_valid", 64'(lane_valid), 64'd0);
    rst = 1'b0;
    sb.delete();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
